// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard unit:
// FSM states, forward-select codes and the load result code.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    function automatic logic reg_hit(
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return we && (rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory request/ready handshake seen by the M stage.
// master drives it (memory side); slave observes it (hazard unit).
interface hazard_ctrl_if;
    logic MemReqM;
    logic MemRdyM;

    modport master (
        output MemReqM,
        output MemRdyM
    );

    modport slave (
        input MemReqM,
        input MemRdyM
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forward select for one E-stage source register.
// The M-stage ALU result wins over the W-stage result.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] Fwd
);

    logic hit_m;
    logic hit_w;

    assign hit_m = reg_hit(RegWriteM, RdM, RsE);
    assign hit_w = reg_hit(RegWriteW, RdW, RsE) && !hit_m;

    always_comb begin
        Fwd = FWD_RF;
        unique case (1'b1)
            hit_m:   Fwd = FWD_M;
            hit_w:   Fwd = FWD_W;
            default: Fwd = FWD_RF;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush
// and a memory-wait FSM with timeout fault and stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [4:0]    Rs1D,
    input  logic [4:0]    Rs2D,
    input  logic [4:0]    Rs1E,
    input  logic [4:0]    Rs2E,
    input  logic [4:0]    RdE,
    input  logic [4:0]    RdM,
    input  logic [4:0]    RdW,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic [1:0]    ResultSrcE,
    input  logic          PCSrcE,
    hazard_ctrl_if.slave  mem,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushW,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          MemErr,
    output logic [31:0]   StallCycles
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    hz_state_t   state;
    logic [7:0]  wait_cnt;
    logic [31:0] stall_cnt;
    logic        lwStall;
    logic        memStall;
    logic        any_stall;

    fwd_sel u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Fwd       (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Fwd       (ForwardBE)
    );

    assign lwStall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0)
                   && ((RdE == Rs1D) || (RdE == Rs2D));

    // Gated by reset so the pipeline shows plain RUN behaviour while held.
    assign memStall = RST_N
                   && ((mem.MemReqM && !mem.MemRdyM) || (state == FAULT));

    always_comb begin
        StallF = lwStall;
        StallD = lwStall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lwStall || PCSrcE;
        FlushW = 1'b0;
        if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    assign any_stall = StallF || StallD || StallE || StallM;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            MemErr   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (memStall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (!memStall) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else begin
                        if (wait_cnt != 8'hFF)
                            wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            state  <= FAULT;
                            MemErr <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    MemErr <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            stall_cnt <= 32'd0;
        else if (any_stall)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign StallCycles = stall_cnt;

endmodule
